// File: rtl/data_sync_pulse.sv
// data_sync_pulse
//   Carries a source-domain data bus plus its level qualifier into the CLK
//   domain. The qualifier passes through a NUM_STAGES flop synchronizer. On
//   the first cycle the synchronized enable is seen high, the bus is captured
//   into a held register, and a one-cycle ENABLE_PULSE is raised in step
//   with that register update. BUSY reports a registered copy of the ACTIVE
//   state.
//   Optional feature macro: DATA_SYNC_CNT_EN adds an 8-bit wrapping
//   CAPTURE_CNT output that counts captures.
//   The reset is synchronous and active-high. It is expected to come from the
//   destination domain's reset synchronizer.

module data_sync_pulse #(
  parameter int NUM_STAGES = 2,  // must be >= 2
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 BUSY
`ifdef DATA_SYNC_CNT_EN
  ,
  output logic [7:0]           CAPTURE_CNT
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [NUM_STAGES-1:0] sync_q;
  logic [NUM_STAGES-1:0] sync_d;
  logic                  en_sync_s;
  state_t                state_q;
  state_t                state_d;
  logic [BUS_WIDTH-1:0]  sync_bus_q;
  logic [BUS_WIDTH-1:0]  sync_bus_d;
  logic                  enable_pulse_q;
  logic                  enable_pulse_d;
  logic                  busy_q;
  logic                  busy_d;

  // The synchronized enable is the last stage of the chain.
  assign en_sync_s = sync_q[NUM_STAGES-1];

  // Shift the raw source enable into the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], BUS_ENABLE};
  end

  // Next-state logic. Capture and pulse happen only on the IDLE->ACTIVE edge.
  always_comb begin
    state_d        = state_q;
    sync_bus_d     = sync_bus_q;
    enable_pulse_d = 1'b0;
    busy_d         = (state_q == ST_ACTIVE);
    case (state_q)
      ST_IDLE: begin
        if (en_sync_s) begin
          state_d        = ST_ACTIVE;
          sync_bus_d     = UNSYNC_BUS;
          enable_pulse_d = 1'b1;
        end else begin
          state_d        = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!en_sync_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset has priority over every event.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q         <= {NUM_STAGES{1'b0}};
      state_q        <= ST_IDLE;
      sync_bus_q     <= {BUS_WIDTH{1'b0}};
      enable_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      sync_bus_q     <= sync_bus_d;
      enable_pulse_q <= enable_pulse_d;
      busy_q         <= busy_d;
    end
  end

  assign SYNC_BUS     = sync_bus_q;
  assign ENABLE_PULSE = enable_pulse_q;
  assign BUSY         = busy_q;

`ifdef DATA_SYNC_CNT_EN
  logic [7:0] capture_cnt_q;
  logic [7:0] capture_cnt_d;

  // Count captures on the same edge that raises ENABLE_PULSE; wraps at 255.
  always_comb begin
    if ((state_q == ST_IDLE) && en_sync_s) begin
      capture_cnt_d = capture_cnt_q + 8'd1;
    end else begin
      capture_cnt_d = capture_cnt_q;
    end
  end

  // Capture counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      capture_cnt_q <= 8'd0;
    end else begin
      capture_cnt_q <= capture_cnt_d;
    end
  end

  assign CAPTURE_CNT = capture_cnt_q;
`endif

endmodule

// File: tb/tb_data_sync_pulse.sv
// Testbench for data_sync_pulse (NUM_STAGES=2, BUS_WIDTH=8).
// The reference model keeps the full history of sampled enable and reset
// values. The synchronized enable at edge n is the enable sampled at edge
// n-NUM_STAGES, provided no reset edge lies in between.
module tb_data_sync_pulse;

  localparam int NS = 2;
  localparam int BW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [BW-1:0] UNSYNC_BUS = 8'h00;
  logic          BUS_ENABLE = 1'b0;
  logic [BW-1:0] SYNC_BUS;
  logic          ENABLE_PULSE;
  logic          BUSY;
`ifdef DATA_SYNC_CNT_EN
  logic [7:0]    CAPTURE_CNT;
`endif

  int checks = 0;
  int failures = 0;
  int pulses_seen = 0;
  int base;
  string phase = "init";

  // reference model state
  bit rst_h[$];
  bit en_h[$];
  bit            m_state = 1'b0;
  bit            m_pulse = 1'b0;
  bit            m_busy = 1'b0;
  logic [BW-1:0] m_bus = 8'h00;
  logic [7:0]    m_cnt = 8'h00;

  logic [7:0] rb;
  int hi;
  int lo;

  data_sync_pulse #(.NUM_STAGES(NS), .BUS_WIDTH(BW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .UNSYNC_BUS   (UNSYNC_BUS),
    .BUS_ENABLE   (BUS_ENABLE),
    .SYNC_BUS     (SYNC_BUS),
    .ENABLE_PULSE (ENABLE_PULSE),
    .BUSY         (BUSY)
`ifdef DATA_SYNC_CNT_EN
    ,
    .CAPTURE_CNT  (CAPTURE_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic bit model_en_sync(input int n);
    if (n - NS < 0) return 1'b0;
    for (int j = n - NS; j < n; j++) begin
      if (rst_h[j]) return 1'b0;
    end
    return en_h[n - NS];
  endfunction

  task automatic model_edge(input bit rst, input bit en, input logic [BW-1:0] bus);
    int n;
    bit es;
    rst_h.push_back(rst);
    en_h.push_back(en);
    n = rst_h.size() - 1;
    if (rst) begin
      m_state = 1'b0; m_pulse = 1'b0; m_busy = 1'b0; m_bus = 8'h00; m_cnt = 8'h00;
    end else begin
      es = model_en_sync(n);
      m_busy  = m_state;
      m_pulse = es && !m_state;
      if (m_pulse) begin
        m_bus = bus;
        m_cnt = m_cnt + 8'd1;
      end
      m_state = es;
    end
  endtask

  // One clock: drive at negedge, optional sub-cycle low glitch, check #1 after posedge.
  task automatic step(input bit rst, input bit en, input logic [BW-1:0] bus, input bit glitch = 1'b0);
    @(negedge CLK);
    RST = rst;
    UNSYNC_BUS = bus;
    BUS_ENABLE = glitch ? 1'b0 : en;
    if (glitch) begin
      #1;
      BUS_ENABLE = en;
    end
    @(posedge CLK);
    model_edge(rst, en, bus);
    #1;
    check("pulse", {31'd0, ENABLE_PULSE}, {31'd0, m_pulse});
    check("sync_bus", {24'd0, SYNC_BUS}, {24'd0, m_bus});
    check("busy", {31'd0, BUSY}, {31'd0, m_busy});
`ifdef DATA_SYNC_CNT_EN
    check("cnt", {24'd0, CAPTURE_CNT}, {24'd0, m_cnt});
`endif
    if (ENABLE_PULSE === 1'b1) pulses_seen++;
  endtask

  initial begin
    // 1: reset with enable already high
    phase = "t1";
    repeat (3) step(1'b1, 1'b1, 8'hA5);
    check("rst_bus", {24'd0, SYNC_BUS}, 32'h0);
    check("rst_pulse", {31'd0, ENABLE_PULSE}, 32'h0);
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'hA5);
    check("no_early_pulse", {31'd0, ENABLE_PULSE}, 32'h0);
    step(1'b0, 1'b1, 8'hA5);
    check("pulse_3rd_edge", {31'd0, ENABLE_PULSE}, 32'h1);
    check("bus_a5", {24'd0, SYNC_BUS}, 32'hA5);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    check("busy_dropped", {31'd0, BUSY}, 32'h0);

    // 2 + 3: latency, then enable held 20 cycles with bus changing at cycle 10
    phase = "t2";
    base = pulses_seen;
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'h3C);
    check("pulse_k1", {31'd0, ENABLE_PULSE}, 32'h0);
    step(1'b0, 1'b1, 8'h3C);
    check("pulse_k2", {31'd0, ENABLE_PULSE}, 32'h1);
    check("bus_3c", {24'd0, SYNC_BUS}, 32'h3C);
    check("busy_k2", {31'd0, BUSY}, 32'h0);
    step(1'b0, 1'b1, 8'h3C);
    check("busy_k3", {31'd0, BUSY}, 32'h1);
    check("pulse_k3", {31'd0, ENABLE_PULSE}, 32'h0);
    phase = "t3";
    for (int i = 4; i < 20; i++) step(1'b0, 1'b1, (i >= 10) ? 8'hFF : 8'h3C);
    check("single_pulse", pulses_seen - base, 32'd1);
    check("bus_held", {24'd0, SYNC_BUS}, 32'h3C);
    repeat (5) step(1'b0, 1'b0, 8'hFF);

    // 4: glitch too short to be sampled -> no 2nd pulse; 3-cycle gap -> 2nd pulse
    phase = "t4";
    base = pulses_seen;
    repeat (4) step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h11, 1'b1);
    repeat (4) step(1'b0, 1'b1, 8'h99);
    check("glitch_one_pulse", pulses_seen - base, 32'd1);
    check("glitch_bus", {24'd0, SYNC_BUS}, 32'h11);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    repeat (4) step(1'b0, 1'b1, 8'h22);
    check("gap_two_pulses", pulses_seen - base, 32'd2);
    check("gap_bus", {24'd0, SYNC_BUS}, 32'h22);
    repeat (4) step(1'b0, 1'b0, 8'h00);

    // 5: reset one cycle after the enable rise
    phase = "t5";
    base = pulses_seen;
    step(1'b0, 1'b1, 8'h5A);
    step(1'b1, 1'b1, 8'h5A);
    repeat (4) step(1'b0, 1'b0, 8'h5A);
    check("aborted_no_pulse", pulses_seen - base, 32'd0);
    check("aborted_bus", {24'd0, SYNC_BUS}, 32'h0);
    repeat (4) step(1'b0, 1'b1, 8'h66);
    check("recapture_pulse", pulses_seen - base, 32'd1);
    check("recapture_bus", {24'd0, SYNC_BUS}, 32'h66);
    repeat (4) step(1'b0, 1'b0, 8'h00);

    // randomized transfers, including short gaps and sporadic resets
    phase = "rand";
    for (int t = 0; t < 60; t++) begin
      rb = 8'($urandom);
      hi = $urandom_range(1, 8);
      lo = $urandom_range(1, 5);
      for (int i = 0; i < hi; i++) step(($urandom_range(0, 29) == 0), 1'b1, rb);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b0, 8'($urandom));
    end

`ifdef DATA_SYNC_CNT_EN
    // 6: 257 legal transfers wrap the counter to 1
    phase = "t6";
    step(1'b1, 1'b0, 8'h00);
    for (int t = 0; t < 257; t++) begin
      repeat (4) step(1'b0, 1'b1, 8'(t));
      repeat (3) step(1'b0, 1'b0, 8'h00);
    end
    check("cnt_wrapped", {24'd0, CAPTURE_CNT}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
